mdu_seq: RTL and testbench



---
 rtl/mdu_seq.sv | 169 ++++++++++++++++
 tb/tb_mdu_seq.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// Iterative MULTU/DIVU sequencer owning HI/LO; one shift-add or restoring-subtract step per clk, WIDTH cycles busy.
// Divider and DIV state exist only when MDU_DIV_EN is defined; otherwise DIVU completes as a one-cycle no-op.
module mdu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div0
);

   localparam int CW = $clog2(WIDTH);

`ifdef MDU_DIV_EN
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`endif

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opa_q, opa_d;     // multiplicand, or divisor
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [WIDTH:0]     mul_sum;
   logic               last;
   logic               accept;
`ifdef MDU_DIV_EN
   logic [WIDTH:0]     div_trial;
   logic               div_ok;
   logic               div0_q, div0_d;
`endif

   assign last   = (cnt_q == CW'(WIDTH - 1));
   assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opa_d    = opa_q;
      mplier_d = mplier_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      mul_sum  = '0;
`ifdef MDU_DIV_EN
      div0_d    = div0_q;
      div_trial = '0;
      div_ok    = 1'b0;
`endif
      if (accept) begin
         cnt_d = '0;
`ifdef MDU_DIV_EN
         div0_d = 1'b0;
`endif
         case (op)
            2'b00: begin
               opa_d    = a;
               mplier_d = b;
               acc_d    = '0;
               state_d  = S_MUL;
            end
            2'b01: begin
`ifdef MDU_DIV_EN
               opa_d   = b;
               acc_d   = {{WIDTH{1'b0}}, a};
               state_d = S_DIV;
`else
               state_d = S_DONE;
`endif
            end
            2'b10: begin
               hi_d    = a;
               state_d = S_IDLE;
            end
            2'b11: begin
               lo_d    = a;
               state_d = S_IDLE;
            end
         endcase
      end else begin
         case (state_q)
            S_MUL: begin
               mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, opa_q} : '0);
               acc_d    = {mul_sum, acc_q[WIDTH-1:1]};
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + 1'b1;
               if (last) begin
                  {hi_d, lo_d} = acc_d;
                  cnt_d        = '0;
                  state_d      = S_DONE;
               end
            end
`ifdef MDU_DIV_EN
            S_DIV: begin
               // Zero divisor never "borrows": quotient fills with ones and the
               // dividend shifts whole into the remainder half.
               div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opa_q};
               div_ok    = !div_trial[WIDTH] || (opa_q == '0);
               if (div_ok)
                  acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
               else
                  acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
               cnt_d = cnt_q + 1'b1;
               if (last) begin
                  hi_d    = acc_d[2*WIDTH-1:WIDTH];
                  lo_d    = acc_d[WIDTH-1:0];
                  div0_d  = (opa_q == '0);
                  cnt_d   = '0;
                  state_d = S_DONE;
               end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opa_q    <= '0;
         mplier_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
`ifdef MDU_DIV_EN
         div0_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opa_q    <= opa_d;
         mplier_q <= mplier_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
`ifdef MDU_DIV_EN
         div0_q   <= div0_d;
`endif
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = (state_q == S_MUL)
`ifdef MDU_DIV_EN
              || (state_q == S_DIV)
`endif
              ;
   assign done = (state_q == S_DONE);
`ifdef MDU_DIV_EN
   assign div0 = div0_q;
`else
   assign div0 = 1'b0;
`endif

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: MULTU/DIVU results, busy length, done pulse, MT*, ignored issue, mid-op reset.
module tb_mdu_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic [31:0] hi, lo;
   logic        busy, done, div0;

   int n_cmp = 0;
   int n_err = 0;
   int cyc;

   mdu_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .div0(div0)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one op and wait out busy; optionally tries an MTHI at busy cycle 5.
   task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input bit inj, input logic [63:0] hold, output int n);
      start = 1'b1; op = o; a = av; b = bv;
      tick();
      start = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         if (n == 16) chk("hold_hilo", {hi, lo}, hold);
         if (inj && n == 5) begin
            start = 1'b1; op = 2'b10; a = 32'h0000_DEAD;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_hi", {32'h0, hi}, 64'h0);
      chk("rst_lo", {32'h0, lo}, 64'h0);
      chk("rst_flags", {61'h0, busy, done, div0}, 64'h0);

      // 7*6
      run_op(2'b00, 32'd7, 32'd6, 1'b0, 64'h0, cyc);
      chk("mul1_cycles", 64'(cyc), 64'd32);
      chk("mul1_done", {63'h0, done}, 64'd1);
      chk("mul1_hilo", {hi, lo}, 64'h0000_0000_0000_002A);
      tick();
      chk("mul1_done_pulse", {63'h0, done}, 64'd0);

      // max*max
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'h2A, cyc);
      chk("mul2_cycles", 64'(cyc), 64'd32);
      chk("mul2_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      tick();

`ifdef MDU_DIV_EN
      run_op(2'b01, 32'd100, 32'd7, 1'b0, 64'hFFFF_FFFE_0000_0001, cyc);
      chk("div1_cycles", 64'(cyc), 64'd32);
      chk("div1_hilo", {hi, lo}, {32'd2, 32'd14});
      chk("div1_div0", {63'h0, div0}, 64'd0);
      tick();
      run_op(2'b01, 32'h1234, 32'd0, 1'b0, {32'd2, 32'd14}, cyc);
      chk("div0_cycles", 64'(cyc), 64'd32);
      chk("div0_hilo", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
      chk("div0_flag", {63'h0, div0}, 64'd1);
      tick();
      chk("div0_sticky", {63'h0, div0}, 64'd1);
      start = 1'b1; op = 2'b11; a = 32'd5;
      tick();
      start = 1'b0;
      chk("mtlo_clr_div0", {63'h0, div0}, 64'd0);
      chk("mtlo_lo", {32'h0, lo}, 64'd5);
`else
      run_op(2'b01, 32'd100, 32'd7, 1'b0, 64'h0, cyc);
      chk("divnop_cycles", 64'(cyc), 64'd0);
      chk("divnop_done", {63'h0, done}, 64'd1);
      chk("divnop_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      chk("divnop_div0", {63'h0, div0}, 64'd0);
      tick();
      chk("divnop_pulse", {62'h0, busy, done}, 64'd0);
`endif

      // ignored MTHI during busy; a changes after acceptance
      run_op(2'b00, 32'h0001_0000, 32'h0003_0000, 1'b1, {hi, lo}, cyc);
      chk("inj_cycles", 64'(cyc), 64'd32);
      chk("inj_hilo", {hi, lo}, 64'h0000_0003_0000_0000);
      tick();

      start = 1'b1; op = 2'b10; a = 32'hAAAA_0000;
      tick();
      chk("mthi_hi", {32'h0, hi}, 64'h0000_0000_AAAA_0000);
      chk("mthi_flags", {62'h0, busy, done}, 64'd0);
      op = 2'b11; a = 32'h0000_5555;
      tick();
      start = 1'b0;
      chk("mtlo_hilo", {hi, lo}, 64'hAAAA_0000_0000_5555);
      chk("mtlo_flags", {62'h0, busy, done}, 64'd0);

      // back-to-back issue from DONE
      run_op(2'b00, 32'd5, 32'd5, 1'b0, 64'hAAAA_0000_0000_5555, cyc);
      chk("b2b1_hilo", {hi, lo}, 64'd25);
      chk("b2b1_done", {63'h0, done}, 64'd1);
      run_op(2'b00, 32'h1234_5678, 32'h10, 1'b0, 64'd25, cyc);
      chk("b2b2_cycles", 64'(cyc), 64'd32);
      chk("b2b2_hilo", {hi, lo}, 64'h0000_0001_2345_6780);
      tick();

      // reset mid-MULTU
      start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd6;
      tick();
      start = 1'b0;
      for (int i = 1; i < 10; i++) tick();
      chk("pre_rst_busy", {63'h0, busy}, 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_flags", {62'h0, busy, done}, 64'd0);
      chk("midrst_hilo", {hi, lo}, 64'h0);
      run_op(2'b00, 32'd3, 32'd3, 1'b0, 64'h0, cyc);
      chk("post_rst_cycles", 64'(cyc), 64'd32);
      chk("post_rst_hilo", {hi, lo}, 64'd9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
